// File: rtl/sharpness_mc_pkg.sv
// Shared types and constants for the multi-channel sharpening stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sharpness_mc_pkg;

  localparam int SHP_LAT = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } win_state_t;

endpackage

// File: rtl/sharpness_mc_sharp_ch_pipe.sv
// One channel of the sharpening datapath: Laplacian, coring, gain, add-back with clamp.
// Latency: 4 cycles from taps to out, every stage registered.
// Backpressure: none; a new tap set may enter every cycle.
module sharp_ch_pipe
  import sharpness_mc_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int GAIN_W    = 12,
  parameter int GAIN_FRAC = 10,
  parameter int CORE_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sel,
  input  logic              bidir,
  input  logic [DATA_W-1:0] prev,
  input  logic [DATA_W-1:0] curr,
  input  logic [DATA_W-1:0] next,
  input  logic [GAIN_W-1:0] gain,
  input  logic [CORE_W-1:0] core,
  output logic [DATA_W-1:0] out
);

  localparam int LW = DATA_W + 3;
  localparam int PW = DATA_W + GAIN_W + 3;
  localparam int CW = PW - GAIN_FRAC;
  localparam int SW = CW + 1;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << DATA_W) - 1);

  logic signed [LW-1:0] lap_c, lap1, mag, core_x, lap_cor, lap2;
  logic signed [PW-1:0] prod;
  logic signed [CW-1:0] corr_c, corr3;
  logic signed [SW-1:0] sum;
  logic [DATA_W-1:0]    curr1, curr2, curr3, out_c;

  always_comb begin
    lap_c = $signed({2'b00, curr, 1'b0}) - $signed({3'b000, prev}) - $signed({3'b000, next});
    if (sel || (!bidir && lap_c[LW-1])) lap_c = '0;

    core_x = $signed({{(LW-CORE_W){1'b0}}, core});
    mag    = lap1[LW-1] ? -lap1 : lap1;
    if (mag <= core_x)   lap_cor = '0;
    else if (lap1[LW-1]) lap_cor = lap1 + core_x;
    else                 lap_cor = lap1 - core_x;

    // arithmetic shift floors toward minus infinity for negative corrections
    prod   = PW'(lap2) * $signed({{(PW-GAIN_W){1'b0}}, gain});
    corr_c = CW'(prod >>> GAIN_FRAC);

    sum = $signed({{(SW-DATA_W){1'b0}}, curr3}) + SW'(corr3);
    if (sum[SW-1])      out_c = '0;
    else if (sum > MAXV) out_c = '1;
    else                 out_c = sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap1  <= '0;
      lap2  <= '0;
      corr3 <= '0;
      curr1 <= '0;
      curr2 <= '0;
      curr3 <= '0;
      out   <= '0;
    end else if (clr) begin
      lap1  <= '0;
      lap2  <= '0;
      corr3 <= '0;
      curr1 <= '0;
      curr2 <= '0;
      curr3 <= '0;
      out   <= '0;
    end else begin
      lap1  <= lap_c;
      curr1 <= curr;
      lap2  <= lap_cor;
      curr2 <= curr1;
      corr3 <= corr_c;
      curr3 <= curr2;
      out   <= out_c;
    end
  end

endmodule

// File: rtl/sharpness_mc.sv
// Multi-channel unsharp-mask sharpener with its own 3-tap window and edge replication.
// Latency: 4 cycles from window issue to shp_out_vld.
// Backpressure: none; results drain across line gaps, i_vs low clears everything but shadows.
module sharpness_mc
  import sharpness_mc_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int DATA_W    = 12,
  parameter int GAIN_W    = 12,
  parameter int GAIN_FRAC = 10,
  parameter int CORE_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_hs,
  input  logic                     i_vs,
  input  logic                     shp_en,
  input  logic                     shp_sel,
  input  logic                     shp_bidir,
  input  logic [N_CH*DATA_W-1:0]   shp_in,
  input  logic [N_CH*GAIN_W-1:0]   shp_gain,
  input  logic [CORE_W-1:0]        shp_core,
  output logic [N_CH*DATA_W-1:0]   shp_out,
  output logic                     shp_out_vld
);

  localparam int PXW = N_CH * DATA_W;

  win_state_t               state;
  logic                     hs_d, clr, hs_fall, iss;
  logic [PXW-1:0]           prev_px, curr_px, iss_prev, iss_curr, iss_next;
  logic [N_CH*GAIN_W-1:0]   gain_sh;
  logic [CORE_W-1:0]        core_sh;
  logic [SHP_LAT-1:0]       vld_sr;

  assign clr         = !i_vs;
  assign hs_fall     = hs_d && !i_hs;
  assign shp_out_vld = vld_sr[SHP_LAT-1];

  // The flush issue happens on the edge-detect cycle itself; ONE has no real prev, so curr is replicated.
  always_comb begin
    iss      = 1'b0;
    iss_prev = curr_px;
    iss_curr = curr_px;
    iss_next = shp_in;
    if (i_vs) begin
      if (hs_fall) begin
        iss      = (state == ST_ONE) || (state == ST_RUN);
        iss_next = curr_px;
        if (state == ST_RUN) iss_prev = prev_px;
      end else if (shp_en) begin
        iss = (state == ST_ONE) || (state == ST_RUN);
        if (state == ST_RUN) iss_prev = prev_px;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      hs_d    <= 1'b0;
      prev_px <= '0;
      curr_px <= '0;
      vld_sr  <= '0;
      gain_sh <= '0;
      core_sh <= '0;
    end else if (clr) begin
      state   <= ST_EMPTY;
      hs_d    <= 1'b0;
      prev_px <= '0;
      curr_px <= '0;
      vld_sr  <= '0;
      gain_sh <= shp_gain;
      core_sh <= shp_core;
    end else begin
      hs_d   <= i_hs;
      vld_sr <= {vld_sr[SHP_LAT-2:0], iss};
      if (hs_fall) begin
        state <= ST_EMPTY;
      end else if (shp_en) begin
        case (state)
          ST_EMPTY: begin
            curr_px <= shp_in;
            state   <= ST_ONE;
          end
          ST_ONE, ST_RUN: begin
            prev_px <= curr_px;
            curr_px <= shp_in;
            state   <= ST_RUN;
          end
          default: state <= ST_EMPTY;
        endcase
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sharp_ch_pipe #(
      .DATA_W    (DATA_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC),
      .CORE_W    (CORE_W)
    ) u_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .sel   (shp_sel),
      .bidir (shp_bidir),
      .prev  (iss_prev[c*DATA_W +: DATA_W]),
      .curr  (iss_curr[c*DATA_W +: DATA_W]),
      .next  (iss_next[c*DATA_W +: DATA_W]),
      .gain  (gain_sh[c*GAIN_W +: GAIN_W]),
      .core  (core_sh),
      .out   (shp_out[c*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_sharpness_mc.sv
// Directed scoreboard bench for sharpness_mc: expected pixels queued at stimulus time, checked on vld.
`timescale 1ns/1ps
module tb_sharpness_mc;
  localparam int N_CH = 3, DATA_W = 12, GAIN_W = 12, GAIN_FRAC = 10, CORE_W = 8;
  localparam int PXW = N_CH * DATA_W;

  logic clk = 1'b0, rst_n = 1'b0, i_hs = 1'b0, i_vs = 1'b0;
  logic shp_en = 1'b0, shp_sel = 1'b0, shp_bidir = 1'b1;
  logic [PXW-1:0]         shp_in = '0;
  logic [N_CH*GAIN_W-1:0] shp_gain = '0;
  logic [CORE_W-1:0]      shp_core = '0;
  logic [PXW-1:0]         shp_out;
  logic                   shp_out_vld;

  int tests = 0, fails = 0, cyc = 0, first_vld = -1, mark = 0, m2 = 0;
  bit mon_on = 1'b1;
  logic [PXW-1:0] sb[$];
  logic [PXW-1:0] e;

  sharpness_mc #(.N_CH(N_CH), .DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .CORE_W(CORE_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .shp_en(shp_en), .shp_sel(shp_sel),
    .shp_bidir(shp_bidir), .shp_in(shp_in), .shp_gain(shp_gain), .shp_core(shp_core),
    .shp_out(shp_out), .shp_out_vld(shp_out_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on && shp_out_vld) begin
      if (first_vld < 0) first_vld = cyc;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_vld: got %h with empty scoreboard", shp_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        assert (shp_out === e) else begin
          fails++;
          $error("FAIL pixel_out: got %h want %h", shp_out, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [PXW-1:0] got, input logic [PXW-1:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic px(input int a, input int b, input int c);
    shp_in = {DATA_W'(c), DATA_W'(b), DATA_W'(a)};
    shp_en = 1'b1;
    i_hs   = 1'b1;
    mark   = cyc;
    @(posedge clk); #1;
  endtask

  task automatic pxs(input int v);
    px(v, v, v);
  endtask

  task automatic exp3(input int a, input int b, input int c);
    sb.push_back({DATA_W'(c), DATA_W'(b), DATA_W'(a)});
  endtask

  task automatic exps(input int v);
    exp3(v, v, v);
  endtask

  task automatic eol;
    shp_en = 1'b0;
    i_hs   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain: %0d results outstanding, want 0", sb.size());
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int g0, input int g1, input int g2, input int core);
    i_vs     = 1'b0;
    shp_gain = {GAIN_W'(g2), GAIN_W'(g1), GAIN_W'(g0)};
    shp_core = CORE_W'(core);
    repeat (2) @(posedge clk);
    #1;
    i_vs = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    chk("reset_out", shp_out, '0);
    chk("reset_vld", PXW'(shp_out_vld), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // flat line and first-result latency
    frame(1024, 1024, 1024, 0);
    first_vld = -1;
    exps(100); exps(100); exps(100);
    pxs(100); pxs(100); m2 = mark; pxs(100); eol; drain;
    chk("latency", PXW'(first_vld), PXW'(m2 + 4));

    // step edge: bidirectional, legacy positive-only, bypass
    exps(100); exps(0); exps(900); exps(500);
    pxs(100); pxs(100); pxs(500); pxs(500); eol; drain;
    shp_bidir = 1'b0;
    exps(100); exps(100); exps(900); exps(500);
    pxs(100); pxs(100); pxs(500); pxs(500); eol; drain;
    shp_bidir = 1'b1;
    shp_sel = 1'b1;
    exps(100); exps(100); exps(500); exps(500);
    pxs(100); pxs(100); pxs(500); pxs(500); eol; drain;
    shp_sel = 1'b0;

    // independent per-channel gains
    frame(1024, 512, 2048, 0);
    exp3(100, 100, 100); exp3(0, 0, 0); exp3(900, 700, 1300); exp3(500, 500, 500);
    pxs(100); pxs(100); pxs(500); pxs(500); eol; drain;

    // coring
    frame(1024, 1024, 1024, 50);
    exps(100); exps(170); exps(100);
    pxs(100); pxs(140); pxs(100); eol; drain;
    frame(1024, 1024, 1024, 90);
    exps(100); exps(140); exps(100);
    pxs(100); pxs(140); pxs(100); eol; drain;

    // saturation, fractional gain, floor rounding of negative corrections
    frame(1024, 1024, 1024, 0);
    exps(0); exps(4095); exps(0);
    pxs(0); pxs(4000); pxs(0); eol; drain;
    frame(512, 512, 512, 0);
    shp_bidir = 1'b0;
    exps(100); exps(500); exps(100);
    pxs(100); pxs(300); pxs(100); eol; drain;
    shp_bidir = 1'b1;
    exps(99); exps(102); exps(99);
    pxs(100); pxs(101); pxs(100); eol; drain;

    // gain change mid-frame ignored until next i_vs low; single-pixel line
    frame(1024, 1024, 1024, 0);
    shp_gain = {3{12'd2048}};
    exps(100); exps(0); exps(900); exps(500);
    pxs(100); pxs(100); pxs(500); pxs(500); eol; drain;
    exps(777);
    pxs(777); eol; drain;
    frame(2048, 2048, 2048, 0);
    shp_bidir = 1'b0;
    exps(100); exps(1100); exps(100);
    pxs(100); pxs(300); pxs(100); eol; drain;
    shp_bidir = 1'b1;

    // i_vs low mid-line clears pipeline and window
    frame(1024, 1024, 1024, 0);
    mon_on = 1'b0;
    repeat (6) pxs(100);
    chk("pre_clear_vld", PXW'(shp_out_vld), PXW'(1));
    i_vs = 1'b0;
    shp_en = 1'b0;
    @(posedge clk); #1;
    chk("clear_vld", PXW'(shp_out_vld), '0);
    chk("clear_out", shp_out, '0);
    i_vs = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;
    exps(777);
    pxs(777); eol; drain;

    // asynchronous reset mid-line
    mon_on = 1'b0;
    repeat (6) pxs(300);
    chk("pre_reset_out", shp_out, {3{12'd300}});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", shp_out, '0);
    chk("async_reset_vld", PXW'(shp_out_vld), '0);
    shp_en = 1'b0;
    i_hs = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;
    frame(1024, 1024, 1024, 0);
    exps(100); exps(0); exps(900); exps(500);
    pxs(100); pxs(100); pxs(500); pxs(500); eol; drain;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
